// File: rtl/sd_spi_target_if.sv
// Byte-stream side of the SPI target: received bytes out, transmit bytes in.
// The target uses the slave modport; the byte producer/consumer uses master.
interface sd_spi_target_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_underrun;

  modport slave (
    output rx_data,
    output rx_valid,
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_underrun
  );

  modport master (
    input  rx_data,
    input  rx_valid,
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_underrun
  );
endinterface

// File: rtl/sd_spi_target.sv
// SPI mode-0 target oversampling SCK/MOSI/CS_n on clk_50; rx_valid and MISO follow pin edges by SYNC_STAGES+2 cycles.
// One-byte holding register with bypass: tx_ready = holding register empty (or being drained this cycle); FILL_BYTE on underrun.
module sd_spi_target #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  FILL_BYTE   = 8'hFF
) (
  input  logic          clk_50,
  input  logic          rst_in,
  input  logic          spi_sck,
  input  logic          spi_mosi,
  input  logic          spi_cs_n,
  output logic          spi_miso,
  output logic          miso_oe,
  output logic          cs_active,
  output logic [15:0]   byte_count,
  sd_spi_target_if.slave stream
);

  localparam logic [2:0] SETTLE = 3'(SYNC_STAGES);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] cs_n_sync_q, cs_n_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   cs_n_prev_q, cs_n_prev_d;
  logic [2:0]             settle_q, settle_d;
  logic                   armed_q, armed_d;

  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        byte_done_q, byte_done_d;
  logic [15:0] byte_count_q, byte_count_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic        tx_underrun_q, tx_underrun_d;
  logic        miso_bit_q, miso_bit_d;

  logic sck_s, mosi_s, cs_n_s;
  logic sck_rise, sck_fall, cs_fall, cs_rise;
  logic start, in_frame, do_rise, do_fall, load, accept, tx_ready;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign cs_n_s = cs_n_sync_q[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  // A select edge only counts once the synchroniser has been seen high after reset,
  // so a CS held low through reset never starts a frame.
  assign cs_fall  = armed_q & cs_n_prev_q & ~cs_n_s;
  assign cs_rise  = cs_n_s & ~cs_n_prev_q;

  assign start    = (state_q == ST_IDLE) & cs_fall;
  assign in_frame = (state_q == ST_ACTIVE) & ~cs_rise;
  assign do_rise  = in_frame & sck_rise;
  assign do_fall  = in_frame & sck_fall;
  assign load     = start | (do_fall & (bit_cnt_q == 3'd0));
  assign tx_ready = ~hold_full_q | load;
  assign accept   = stream.tx_valid & tx_ready;

  // Synchronisers and edge history
  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    cs_n_sync_d = {cs_n_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    sck_prev_d  = sck_s;
    cs_n_prev_d = cs_n_s;
    settle_d    = (settle_q == SETTLE) ? settle_q : settle_q + 3'd1;
    armed_d     = armed_q | ((settle_q == SETTLE) & cs_n_s);
  end

  // FSM: state register
  always_ff @(posedge clk_50) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cs_fall) state_d = ST_ACTIVE;
      ST_ACTIVE: if (cs_rise) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    miso_oe   = 1'b0;
    cs_active = 1'b0;
    spi_miso  = 1'b1;
    if (state_q == ST_ACTIVE) begin
      miso_oe   = 1'b1;
      cs_active = 1'b1;
      spi_miso  = miso_bit_q;
    end
  end

  // Datapath
  always_comb begin
    rx_shift_d    = rx_shift_q;
    bit_cnt_d     = bit_cnt_q;
    byte_done_d   = 1'b0;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    byte_count_d  = byte_count_q;
    tx_shift_d    = tx_shift_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    tx_underrun_d = 1'b0;
    miso_bit_d    = tx_shift_q[7];

    if (load) begin
      if (hold_full_q) begin
        tx_shift_d = hold_q;
        if (accept) hold_d = stream.tx_data;
        else        hold_full_d = 1'b0;
      end else if (accept) begin
        tx_shift_d = stream.tx_data;
      end else begin
        tx_shift_d    = FILL_BYTE;
        tx_underrun_d = 1'b1;
      end
    end else begin
      if (accept) begin
        hold_d      = stream.tx_data;
        hold_full_d = 1'b1;
      end
      if (do_fall) tx_shift_d = {tx_shift_q[6:0], 1'b1};
    end

    if (do_rise) begin
      rx_shift_d  = {rx_shift_q[6:0], mosi_s};
      bit_cnt_d   = bit_cnt_q + 3'd1;
      byte_done_d = (bit_cnt_q == 3'd7);
    end

    // Completed byte is published one cycle after its last bit is shifted in.
    if (byte_done_q) begin
      rx_data_d  = rx_shift_q;
      rx_valid_d = 1'b1;
      if (byte_count_q != 16'hFFFF) byte_count_d = byte_count_q + 16'd1;
    end

    if (start) begin
      bit_cnt_d    = 3'd0;
      byte_count_d = 16'd0;
    end
    if ((state_q == ST_ACTIVE) && cs_rise) bit_cnt_d = 3'd0;
  end

  always_ff @(posedge clk_50) begin
    if (rst_in) begin
      sck_sync_q    <= '0;
      mosi_sync_q   <= '1;
      cs_n_sync_q   <= '1;
      sck_prev_q    <= 1'b0;
      cs_n_prev_q   <= 1'b1;
      settle_q      <= 3'd0;
      armed_q       <= 1'b0;
      bit_cnt_q     <= 3'd0;
      rx_shift_q    <= 8'd0;
      rx_data_q     <= 8'd0;
      rx_valid_q    <= 1'b0;
      byte_done_q   <= 1'b0;
      byte_count_q  <= 16'd0;
      tx_shift_q    <= FILL_BYTE;
      hold_q        <= 8'd0;
      hold_full_q   <= 1'b0;
      tx_underrun_q <= 1'b0;
      miso_bit_q    <= 1'b1;
    end else begin
      sck_sync_q    <= sck_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      cs_n_sync_q   <= cs_n_sync_d;
      sck_prev_q    <= sck_prev_d;
      cs_n_prev_q   <= cs_n_prev_d;
      settle_q      <= settle_d;
      armed_q       <= armed_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      byte_done_q   <= byte_done_d;
      byte_count_q  <= byte_count_d;
      tx_shift_q    <= tx_shift_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      tx_underrun_q <= tx_underrun_d;
      miso_bit_q    <= miso_bit_d;
    end
  end

  assign stream.rx_data     = rx_data_q;
  assign stream.rx_valid    = rx_valid_q;
  assign stream.tx_ready    = tx_ready;
  assign stream.tx_underrun = tx_underrun_q;
  assign byte_count         = byte_count_q;

endmodule

// File: tb/tb_sd_spi_target.sv
// Randomised bench for sd_spi_target: SPI initiator, byte producer, queue-based reference model and scoreboard.
// The initiator drops SCK and raises CS together at frame end, so a frame of N bits performs 1+(N-1)/8 tx loads.
module tb_sd_spi_target;
  localparam int SYNC = 2;
  localparam int HALF = 8;   // SCK half period in clk_50 cycles (SCK = clk/16)

  logic        clk_50   = 1'b0;
  logic        rst_in   = 1'b1;
  logic        spi_sck  = 1'b0;
  logic        spi_mosi = 1'b1;
  logic        spi_cs_n = 1'b1;
  logic        spi_miso, miso_oe, cs_active;
  logic [15:0] byte_count;

  sd_spi_target_if u_if();

  sd_spi_target #(.SYNC_STAGES(SYNC), .FILL_BYTE(8'hFF)) dut (
    .clk_50     (clk_50),
    .rst_in     (rst_in),
    .spi_sck    (spi_sck),
    .spi_mosi   (spi_mosi),
    .spi_cs_n   (spi_cs_n),
    .spi_miso   (spi_miso),
    .miso_oe    (miso_oe),
    .cs_active  (cs_active),
    .byte_count (byte_count),
    .stream     (u_if)
  );

  always #10 clk_50 = ~clk_50;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk_50) cyc <= cyc + 1;

  logic [7:0] exp_rx[$];
  logic [7:0] exp_miso[$];
  logic [7:0] got_miso[$];
  logic [7:0] model_tx[$];   // bytes handed to the producer and not yet loaded for transmission
  logic [7:0] prod_q[$];     // bytes the producer still has to hand over
  logic [7:0] mosi_buf[0:31];
  int         obs_und = 0;
  int         byp_at  = -1;
  logic [7:0] byp_dat = 8'h00;
  bit         byp_active = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_50);
    #3;
  endtask

  // Scoreboard monitor
  initial begin
    forever begin
      @(negedge clk_50);
      if (u_if.rx_valid === 1'b1) begin
        if (exp_rx.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rx_unexpected: got %0h, expected no rx_valid", u_if.rx_data);
        end else begin
          chk("rx_byte", u_if.rx_data, exp_rx.pop_front());
        end
      end
      if (u_if.tx_underrun === 1'b1) obs_und++;
      while (got_miso.size() > 0) begin
        if (exp_miso.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL miso_unexpected: got %0h, expected nothing", got_miso.pop_front());
        end else begin
          chk("miso_byte", got_miso.pop_front(), exp_miso.pop_front());
        end
      end
    end
  end

  // Byte producer: offers prod_q in order, or a single bypass byte on cycle byp_at
  initial begin
    bit acc;
    u_if.tx_valid = 1'b0;
    u_if.tx_data  = 8'h00;
    forever begin
      @(negedge clk_50);
      acc = u_if.tx_valid & u_if.tx_ready;
      if (byp_active) chk("bypass_tx_ready", u_if.tx_ready, 1);
      @(posedge clk_50);
      #2;
      if (acc && !byp_active) void'(prod_q.pop_front());
      byp_active = (cyc == byp_at);
      if (byp_active) begin
        u_if.tx_valid = 1'b1;
        u_if.tx_data  = byp_dat;
      end else if (prod_q.size() > 0) begin
        u_if.tx_valid = 1'b1;
        u_if.tx_data  = prod_q[0];
      end else begin
        u_if.tx_valid = 1'b0;
      end
    end
  end

  task automatic offer(input logic [7:0] b);
    prod_q.push_back(b);
    model_tx.push_back(b);
  endtask

  task automatic run_frame(input int nbits, input bit byp);
    int         nloads, exp_und, und0;
    logic [7:0] ld[$];
    logic [7:0] cap;
    cap     = 8'h00;
    exp_und = 0;
    nloads  = 1 + (nbits - 1) / 8;
    for (int j = 0; j < nloads; j++) begin
      if (model_tx.size() > 0) ld.push_back(model_tx.pop_front());
      else begin
        ld.push_back(8'hFF);
        exp_und++;
      end
    end
    for (int j = 0; j < nbits / 8; j++) begin
      exp_miso.push_back(ld[j]);
      exp_rx.push_back(mosi_buf[j]);
    end
    und0 = obs_und;
    @(posedge clk_50);
    #3;
    spi_cs_n = 1'b0;
    if (byp) begin
      byp_dat = 8'h5A;
      byp_at  = cyc + SYNC;
    end
    for (int b = 0; b < nbits; b++) begin
      spi_mosi = mosi_buf[b / 8][7 - (b % 8)];
      wait_cyc(HALF);
      spi_sck = 1'b1;
      cap = {cap[6:0], spi_miso};
      if (b == 0) begin
        chk("cs_active_in_frame", cs_active, 1);
        chk("miso_oe_in_frame", miso_oe, 1);
      end
      if (b % 8 == 7) got_miso.push_back(cap);
      wait_cyc(HALF);
      spi_sck = 1'b0;
      if (b == nbits - 1) spi_cs_n = 1'b1;
    end
    spi_mosi = 1'b1;
    wait_cyc(3 * HALF);
    chk("underrun_pulses", obs_und - und0, exp_und);
    chk("byte_count", byte_count, nbits / 8);
    chk("idle_miso_oe", miso_oe, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    int und0;
    wait_cyc(4);
    chk("rst_spi_miso", spi_miso, 1);
    chk("rst_miso_oe", miso_oe, 0);
    chk("rst_rx_data", u_if.rx_data, 0);
    chk("rst_rx_valid", u_if.rx_valid, 0);
    chk("rst_tx_ready", u_if.tx_ready, 1);
    chk("rst_tx_underrun", u_if.tx_underrun, 0);
    chk("rst_cs_active", cs_active, 0);
    chk("rst_byte_count", byte_count, 0);
    rst_in = 1'b0;
    wait_cyc(8);

    // Loopback byte
    offer(8'hA5);
    wait_cyc(6);
    chk("hold_full_tx_ready", u_if.tx_ready, 0);
    mosi_buf[0] = 8'h3C;
    run_frame(8, 1'b0);

    // Underrun, two-byte frame
    mosi_buf[0] = 8'h81;
    mosi_buf[1] = 8'h7E;
    run_frame(16, 1'b0);

    // Back-to-back streaming
    for (int i = 1; i <= 16; i++) begin
      offer(8'(i));
      mosi_buf[i - 1] = 8'($urandom_range(0, 255));
    end
    wait_cyc(6);
    run_frame(128, 1'b0);

    // Bypass on the CS-assert load cycle
    model_tx.push_back(8'h5A);
    mosi_buf[0] = 8'hC0;
    run_frame(8, 1'b1);
    chk("bypass_hold_empty", u_if.tx_ready, 1);

    // CS abort after 5 bits, then an aligned frame using the held byte
    offer(8'hC3);
    offer(8'h96);
    wait_cyc(6);
    mosi_buf[0] = 8'hF0;
    run_frame(5, 1'b0);
    chk("abort_hold_retained", u_if.tx_ready, 0);
    mosi_buf[0] = 8'h69;
    run_frame(8, 1'b0);

    // Reset mid-frame with CS held low
    @(posedge clk_50);
    #3;
    spi_cs_n = 1'b0;
    for (int b = 0; b < 3; b++) begin
      spi_mosi = 1'($urandom_range(0, 1));
      wait_cyc(HALF);
      spi_sck = 1'b1;
      wait_cyc(HALF);
      spi_sck = 1'b0;
    end
    rst_in = 1'b1;
    wait_cyc(1);
    rst_in = 1'b0;
    chk("midrst_spi_miso", spi_miso, 1);
    chk("midrst_miso_oe", miso_oe, 0);
    chk("midrst_rx_data", u_if.rx_data, 0);
    chk("midrst_tx_ready", u_if.tx_ready, 1);
    chk("midrst_cs_active", cs_active, 0);
    chk("midrst_byte_count", byte_count, 0);
    und0 = obs_und;
    for (int b = 0; b < 8; b++) begin
      spi_mosi = 1'($urandom_range(0, 1));
      wait_cyc(HALF);
      spi_sck = 1'b1;
      wait_cyc(HALF);
      spi_sck = 1'b0;
    end
    chk("midrst_stays_idle", cs_active, 0);
    chk("midrst_no_load", obs_und - und0, 0);
    spi_cs_n = 1'b1;
    spi_mosi = 1'b1;
    wait_cyc(4 * HALF);
    mosi_buf[0] = 8'h2D;
    run_frame(8, 1'b0);

    // Randomised frames
    for (int r = 0; r < 6; r++) begin
      int npre, nbytes, nbits;
      npre = $urandom_range(0, 3);
      for (int i = 0; i < npre; i++) offer(8'($urandom_range(0, 255)));
      nbytes = $urandom_range(1, 3);
      nbits  = nbytes * 8;
      if ($urandom_range(0, 3) == 0) nbits = 8 * (nbytes - 1) + $urandom_range(1, 7);
      for (int j = 0; j < 4; j++) mosi_buf[j] = 8'($urandom_range(0, 255));
      wait_cyc(6);
      run_frame(nbits, 1'b0);
    end

    wait_cyc(10);
    chk("rx_queue_drained", exp_rx.size(), 0);
    chk("miso_queue_drained", exp_miso.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
